// File: rtl/rst_cond.sv
// Reset conditioner and time base: synchronizes/stretches reset release, flags RUN,
// emits a periodic tick. Define RST_CNT_EN to build the saturating soft-reset counter.
module rst_cond #(
  parameter int SYNC_STAGES = 2,
  parameter int STRETCH_CYC = 4,
  parameter int TICK_DIV    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       soft_rst,
  output logic       rst_n,
  output logic       ready,
  output logic       tick,
  output logic [7:0] rst_cnt
);

  localparam int              TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0]   TICK_MAX = TW'(TICK_DIV - 1);
  localparam logic [7:0]      STR_LOAD = 8'(STRETCH_CYC - 1);

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    STRETCH = 2'd1,
    RUN     = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [7:0]             str_cnt_q, str_cnt_d;
  logic [TW-1:0]          tick_cnt_q, tick_cnt_d;
  logic                   rst_n_q, rst_n_d;
  logic                   ready_q, ready_d;
  logic                   sync_ok;

  assign sync_ok = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], 1'b1};
    state_d    = state_q;
    str_cnt_d  = str_cnt_q;
    tick_cnt_d = '0;
    rst_n_d    = rst_n_q;
    ready_d    = ready_q;
    case (state_q)
      HOLD: begin
        if (sync_ok) begin
          state_d   = STRETCH;
          str_cnt_d = STR_LOAD;
        end
      end
      STRETCH: begin
        // A soft request restarts the stretch, even on the cycle it would end.
        if (soft_rst) begin
          str_cnt_d = STR_LOAD;
        end else if (str_cnt_q != 8'd0) begin
          str_cnt_d = str_cnt_q - 8'd1;
        end else begin
          state_d = RUN;
          rst_n_d = 1'b1;
          ready_d = 1'b1;
        end
      end
      RUN: begin
        if (soft_rst) begin
          state_d   = STRETCH;
          str_cnt_d = STR_LOAD;
          rst_n_d   = 1'b0;
          ready_d   = 1'b0;
        end else begin
          tick_cnt_d = (tick_cnt_q == TICK_MAX) ? '0 : tick_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = HOLD;
        rst_n_d = 1'b0;
        ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= HOLD;
      sync_q     <= '0;
      str_cnt_q  <= 8'd0;
      tick_cnt_q <= '0;
      rst_n_q    <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      str_cnt_q  <= str_cnt_d;
      tick_cnt_q <= tick_cnt_d;
      rst_n_q    <= rst_n_d;
      ready_q    <= ready_d;
    end
  end

  assign rst_n = rst_n_q;
  assign ready = ready_q;
  assign tick  = (state_q == RUN) && (tick_cnt_q == TICK_MAX);

`ifdef RST_CNT_EN
  // soft_seq marks a stretch that began from a soft request rather than from rst.
  logic       soft_seq_q, soft_seq_d;
  logic [7:0] rst_cnt_q, rst_cnt_d;

  always_comb begin
    soft_seq_d = soft_seq_q;
    rst_cnt_d  = rst_cnt_q;
    if (state_q == HOLD) begin
      soft_seq_d = 1'b0;
    end else if (state_q == RUN && state_d == STRETCH) begin
      soft_seq_d = 1'b1;
    end
    if (state_q == STRETCH && state_d == RUN && soft_seq_q && rst_cnt_q != 8'd255) begin
      rst_cnt_d = rst_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      soft_seq_q <= 1'b0;
      rst_cnt_q  <= 8'd0;
    end else begin
      soft_seq_q <= soft_seq_d;
      rst_cnt_q  <= rst_cnt_d;
    end
  end

  assign rst_cnt = rst_cnt_q;
`else
  assign rst_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_rst_cond.sv
// Bench for rst_cond: directed power-up/soft-reset/async-reset scenarios plus random
// soft_rst/rst traffic, all checked every cycle against an edge-count reference model.
module tb_rst_cond;

  localparam int SYNC = 2;
  localparam int STR  = 4;
  localparam int TD   = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       soft_rst = 1'b0;
  logic       rst_n, ready, tick;
  logic [7:0] rst_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  rst_cond #(.SYNC_STAGES(SYNC), .STRETCH_CYC(STR), .TICK_DIV(TD)) dut (
    .clk      (clk),
    .rst      (rst),
    .soft_rst (soft_rst),
    .rst_n    (rst_n),
    .ready    (ready),
    .tick     (tick),
    .rst_cnt  (rst_cnt)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // Reference model: edges since release, absolute edge at which rst_n must rise,
  // and cycles spent in RUN (tick on every TD-th one).
  int m_n      = 0;
  bit m_run    = 1'b0;
  bit m_soft   = 1'b0;
  int m_rise   = SYNC + STR + 1;
  int m_age    = 0;
  int m_cnt    = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_n    = 0;
      m_run  = 1'b0;
      m_soft = 1'b0;
      m_rise = SYNC + STR + 1;
      m_age  = 0;
      m_cnt  = 0;
    end else begin
      m_n++;
      if (m_run && soft_rst) begin
        m_run  = 1'b0;
        m_soft = 1'b1;
        m_rise = m_n + STR;
      end else if (!m_run && m_n > SYNC + 1 && soft_rst) begin
        m_rise = m_n + STR;
      end else if (!m_run && m_n == m_rise) begin
        m_run = 1'b1;
        m_age = 0;
        if (m_soft && m_cnt < 255) m_cnt++;
      end else if (m_run) begin
        m_age++;
      end
    end
  end

  function automatic int exp_cnt();
`ifdef RST_CNT_EN
    return m_cnt;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // scoreboard: every cycle, DUT outputs against the model
  always @(negedge clk) begin
    chk("mdl_rst_n", {31'd0, rst_n}, {31'd0, m_run});
    chk("mdl_ready", {31'd0, ready}, {31'd0, m_run});
    chk("mdl_tick",  {31'd0, tick},  {31'd0, m_run && (m_age % TD == TD - 1)});
    chk("mdl_cnt",   {24'd0, rst_cnt}, 32'(exp_cnt()));
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_soft();
    soft_rst = 1'b1;
    step();
    soft_rst = 1'b0;
  endtask

  task automatic release_and_check(input string tag);
    rst = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      step();
      chk({tag, "_rst_n"}, {31'd0, rst_n}, {31'd0, (e >= 7)});
    end
  endtask

  initial begin
    logic [7:0] cnt_base;
    // power-up
    repeat (3) step();
    chk("reset_rst_n", {31'd0, rst_n}, 32'd0);
    chk("reset_ready", {31'd0, ready}, 32'd0);
    chk("reset_tick",  {31'd0, tick}, 32'd0);
    chk("reset_cnt",   {24'd0, rst_cnt}, 32'd0);
    release_and_check("pwr");
    chk("pwr_ready", {31'd0, ready}, 32'd1);
    for (int e = 8; e <= 16; e++) begin
      step();
      chk("pwr_tick", {31'd0, tick}, {31'd0, (e == 11 || e == 16)});
    end

    // soft pulse in RUN
    pulse_soft();
    chk("soft_fall", {31'd0, rst_n}, 32'd0);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("soft_rst_n", {31'd0, rst_n}, {31'd0, (k == 4)});
    end
`ifdef RST_CNT_EN
    chk("soft_cnt1", {24'd0, rst_cnt}, 32'd1);
`else
    chk("soft_cnt1", {24'd0, rst_cnt}, 32'd0);
`endif
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("soft_tick", {31'd0, tick}, {31'd0, (k == 4)});
    end

    // second pulse inside the stretch
    pulse_soft();
    step();
    step();
    pulse_soft();
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("restretch_rst_n", {31'd0, rst_n}, {31'd0, (k == 4)});
    end
`ifdef RST_CNT_EN
    chk("restretch_cnt", {24'd0, rst_cnt}, 32'd2);
`else
    chk("restretch_cnt", {24'd0, rst_cnt}, 32'd0);
`endif

    // asynchronous assert mid-cycle
    step();
    #1 rst = 1'b1;
    #1;
    chk("async_rst_n", {31'd0, rst_n}, 32'd0);
    chk("async_ready", {31'd0, ready}, 32'd0);
    chk("async_tick",  {31'd0, tick}, 32'd0);
    chk("async_cnt",   {24'd0, rst_cnt}, 32'd0);
    step();
    release_and_check("rerel");

    // soft_rst while rst is held is ignored
    rst = 1'b1;
    soft_rst = 1'b1;
    repeat (3) step();
    soft_rst = 1'b0;
    chk("ign_rst_n", {31'd0, rst_n}, 32'd0);
    release_and_check("ign");
    chk("ign_cnt", {24'd0, rst_cnt}, 32'd0);

    // saturation
    for (int s = 0; s < 300; s++) begin
      pulse_soft();
      repeat (4) step();
    end
`ifdef RST_CNT_EN
    cnt_base = 8'd255;
`else
    cnt_base = 8'd0;
`endif
    chk("sat_cnt", {24'd0, rst_cnt}, {24'd0, cnt_base});
    chk("sat_rst_n", {31'd0, rst_n}, 32'd1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        repeat ($urandom_range(1, 3)) step();
        rst = 1'b0;
      end else if ($urandom_range(0, 99) == 0) begin
        soft_rst = 1'b1;
        repeat ($urandom_range(5, 12)) step();
        soft_rst = 1'b0;
      end else begin
        soft_rst = ($urandom_range(0, 11) == 0);
        step();
      end
    end
    soft_rst = 1'b0;
    repeat (12) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
